// File: rtl/regfile_wport_arb_pkg.sv
// Shared definitions for register-file write-port control.
// State encoding and counter width helpers.
package regfile_ctrl_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // One extra bit so the sweep counter can reach NUM_REGS.
    function automatic int CLR_CNT_W(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wport_arb_if.sv
// Writeback requester bundle for the register-file write port.
// Requesters drive master, the arbiter takes slave.
interface regfile_wport_arb_if #(
    parameter int NUM_REQ       = 2,
    parameter int REGADDR_WIDTH = 3,
    parameter int DATA_WIDTH    = 16
);

    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ*REGADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;
    logic [NUM_REQ-1:0]               req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/regfile_wport_arb_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches rr, rr+1, ... mod NUM_REQ for the first active request.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = regfile_ctrl_pkg::idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    // Pick the first requester at or after the pointer.
    always_comb begin
        int j;
        logic [IDX_W-1:0] jj;
        j         = 0;
        jj        = '0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(rr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jj = IDX_W'(j);
            if (!grant_any && req[jj]) begin
                grant[jj] = 1'b1;
                grant_idx = jj;
                grant_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wport_arb.sv
// Register-file write-port controller: round-robin writeback
// arbitration plus a sequenced whole-file clear.
module regfile_wport_arb
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int REGADDR_WIDTH = 3,
    parameter int NUM_REGS      = 1 << REGADDR_WIDTH,
    parameter int NUM_REQ       = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    regfile_wport_arb_if.slave       bus,
    input  logic                     clear_start,
    output logic                     clear_busy,
    output logic                     clear_done,
    output logic [REGADDR_WIDTH-1:0] write_reg,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic                     reg_write
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CW    = CLR_CNT_W(REGADDR_WIDTH);

    localparam logic [CW-1:0]    CLR_LAST = CW'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    logic [1:0]               state;
    logic [IDX_W-1:0]         rr;
    logic [CW-1:0]            clr_cnt;
    logic [NUM_REQ-1:0]       gnt;
    logic [IDX_W-1:0]         gnt_idx;
    logic                     gnt_any;
    logic                     arb_en;
    logic [IDX_W-1:0]         rr_next;
    logic [REGADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (bus.req_valid),
        .rr        (rr),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .grant_any (gnt_any)
    );

    // Grants only in IDLE, and a clear request pre-empts them.
    always_comb begin
        arb_en        = (state == IDLE) && !clear_start;
        bus.req_ready = arb_en ? gnt : '0;
        sel_addr = bus.req_addr[gnt_idx*REGADDR_WIDTH +: REGADDR_WIDTH];
        sel_data = bus.req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        rr_next  = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
    end

    // Status flags decode straight from the state register.
    always_comb begin
        clear_busy = (state != IDLE);
        clear_done = (state == DONE);
    end

    // FSM, round-robin pointer, sweep counter and write-port register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr         <= '0;
            clr_cnt    <= '0;
            write_reg  <= '0;
            write_data <= '0;
            reg_write  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear_start) begin
                        state     <= CLEAR;
                        clr_cnt   <= '0;
                        reg_write <= 1'b0;
                    end else if (gnt_any) begin
                        write_reg  <= sel_addr;
                        write_data <= sel_data;
                        reg_write  <= 1'b1;
                        rr         <= rr_next;
                    end else begin
                        reg_write <= 1'b0;
                    end
                end
                CLEAR: begin
                    write_reg  <= clr_cnt[REGADDR_WIDTH-1:0];
                    write_data <= '0;
                    reg_write  <= 1'b1;
                    clr_cnt    <= clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    reg_write <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    reg_write <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Scoreboard bench for regfile_wport_arb.
// Expected writes are queued with the cycle they must appear in.
module tb_regfile_wport_arb;

    localparam int NR = 2;
    localparam int AW = 3;
    localparam int DW = 16;
    localparam int NREGS = 1 << AW;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk;
    logic          reset;
    logic          clear_start;
    logic          clear_busy;
    logic          clear_done;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic          reg_write;

    regfile_wport_arb_if #(
        .NUM_REQ       (NR),
        .REGADDR_WIDTH (AW),
        .DATA_WIDTH    (DW)
    ) bus ();

    regfile_wport_arb #(
        .DATA_WIDTH    (DW),
        .REGADDR_WIDTH (AW),
        .NUM_REGS      (NREGS),
        .NUM_REQ       (NR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .reg_write   (reg_write)
    );

    wr_t q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  mdl_rr = 0;
    int  clr_left = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic v,
                           input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.req_valid[i]         = v;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic tick();
        wr_t e;
        logic [NR-1:0] exp_rdy;
        int g;
        @(negedge clk);
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("wr_en", 32'(reg_write), 32'd1);
            check("wr_addr", 32'(write_reg), 32'(e.addr));
            check("wr_data", 32'(write_data), 32'(e.data));
        end else begin
            check("wr_idle", 32'(reg_write), 32'd0);
        end
        check("busy", 32'(clear_busy), 32'(clr_left > 0));
        check("done", 32'(clear_done), 32'(clr_left == 1));
        exp_rdy = '0;
        g = -1;
        if (clr_left == 0 && !clear_start) begin
            for (int i = 0; i < NR; i++) begin
                int j;
                j = (mdl_rr + i) % NR;
                if (g < 0 && bus.req_valid[j]) g = j;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        check("ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (clr_left > 0) begin
            clr_left--;
        end else if (clear_start) begin
            clr_left = NREGS + 1;
            for (int k = 0; k < NREGS; k++) begin
                e.due  = cyc + 2 + k;
                e.addr = AW'(k);
                e.data = '0;
                q.push_back(e);
            end
        end else if (g >= 0) begin
            e.due  = cyc + 1;
            e.addr = bus.req_addr[g*AW +: AW];
            e.data = bus.req_data[g*DW +: DW];
            q.push_back(e);
            mdl_rr = (g + 1) % NR;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        clear_start   = 1'b0;
        reset         = 1'b1;
        #1;
        check("rst_wr_en", 32'(reg_write), 32'd0);
        check("rst_wr_addr", 32'(write_reg), 32'd0);
        check("rst_wr_data", 32'(write_data), 32'd0);
        check("rst_busy", 32'(clear_busy), 32'd0);
        check("rst_done", 32'(clear_done), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        q.delete();
        mdl_rr   = 0;
        clr_left = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        clear_start   = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        repeat (2) @(posedge clk);
        do_reset();
        repeat (2) tick();

        set_req(1, 1'b1, 3'd5, 16'hBEEF);
        tick();
        bus.req_valid = '0;
        repeat (2) tick();

        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, AW'(i), 16'h1000 + DW'(i));
            set_req(1, 1'b1, AW'(7 - i), 16'h2000 + DW'(i));
            tick();
        end
        bus.req_valid = '0;
        repeat (2) tick();

        set_req(0, 1'b1, 3'd2, 16'h1234);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (10) tick();
        bus.req_valid = '0;
        repeat (2) tick();

        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (5) tick();
        do_reset();
        repeat (3) tick();
        set_req(0, 1'b1, 3'd6, 16'hA5A5);
        tick();
        bus.req_valid = '0;
        set_req(1, 1'b1, 3'd3, 16'h5A5A);
        tick();
        bus.req_valid = '0;
        repeat (2) tick();

        clear_start = 1'b1;
        repeat (2 * (NREGS + 2) + 1) tick();
        clear_start = 1'b0;
        repeat (NREGS + 3) tick();

        for (int c = 0; c < 80; c++) begin
            set_req(0, 1'($urandom_range(0, 1)),
                    AW'($urandom), DW'($urandom));
            set_req(1, 1'($urandom_range(0, 1)),
                    AW'($urandom), DW'($urandom));
            clear_start = ($urandom_range(0, 19) == 0);
            tick();
        end
        bus.req_valid = '0;
        clear_start   = 1'b0;
        for (int c = 0; c < 40 && (q.size() > 0 || clr_left > 0); c++) begin
            tick();
        end
        check("drain", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
